// File: rtl/hazard_scoreboard_if.sv
// Decode-side fields in, hazard/forward controls out, bundled between the
// pipeline control (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int REG_AW  = 5,
  parameter int N_SRC   = 2,
  parameter int MEM_LAT = 1
);
  localparam int S    = MEM_LAT + 2;
  localparam int FW_W = $clog2(S);

  logic                    d_valid;
  logic [N_SRC*REG_AW-1:0] d_rs;
  logic [REG_AW-1:0]       d_rd;
  logic                    d_we;
  logic                    d_is_load;
  logic                    branch_taken_e;
  logic                    stall;
  logic                    flush;
  logic [N_SRC*FW_W-1:0]   fw_sel;
  logic [31:0]             stall_cnt;

  modport master (
    output d_valid, d_rs, d_rd, d_we, d_is_load, branch_taken_e,
    input  stall, flush, fw_sel, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rd, d_we, d_is_load, branch_taken_e,
    output stall, flush, fw_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destinations (E, M1..Mn, W) driving
// E-stage operand forwarding, the Decode load-use stall and a stall counter.
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int N_SRC   = 2,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  bus
);
  localparam int S    = MEM_LAT + 2;
  localparam int FW_W = $clog2(S);

  logic                    r_vld [S];
  logic [REG_AW-1:0]       r_rd  [S];
  logic                    r_wr  [S];
  logic                    r_ld  [S];
  logic [N_SRC*REG_AW-1:0] r_rs_e;
  logic [31:0]             r_stall_cnt;

  logic                    w_wr_d;
  logic                    w_issue;
  logic                    w_raw_stall;
  logic                    w_stall;
  logic [N_SRC*FW_W-1:0]   w_fw_sel;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hffff_ffff)) ? v + 32'd1 : v;
  endfunction

  assign w_wr_d  = bus.d_we & (bus.d_rd != '0);
  assign w_stall = w_raw_stall & ~bus.branch_taken_e;
  assign w_issue = bus.d_valid & ~w_stall & ~bus.branch_taken_e;

  // Decode -> slot 0 (E); slots then advance unconditionally toward W
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < S; k++) r_vld[k] <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_vld[0] <= w_issue;
      for (int k = 1; k < S; k++) r_vld[k] <= r_vld[k-1];
      r_stall_cnt <= sat_inc(r_stall_cnt, w_stall);
    end
  end

  always_ff @(posedge clk) begin
    r_rd[0] <= bus.d_rd;
    r_wr[0] <= w_wr_d;
    r_ld[0] <= bus.d_is_load;
    r_rs_e  <= bus.d_rs;
    for (int k = 1; k < S; k++) begin
      r_rd[k] <= r_rd[k-1];
      r_wr[k] <= r_wr[k-1];
      r_ld[k] <= r_ld[k-1];
    end
  end

  // Scan oldest to youngest so the nearest producer overrides; loads only at W
  always_comb begin
    w_fw_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      for (int k = S - 1; k >= 1; k--) begin
        if (r_vld[0] && (r_rs_e[i*REG_AW +: REG_AW] != '0) &&
            r_vld[k] && r_wr[k] && (r_rd[k] == r_rs_e[i*REG_AW +: REG_AW]) &&
            (!r_ld[k] || (k == S - 1))) begin
          w_fw_sel[i*FW_W +: FW_W] = FW_W'(k);
        end
      end
    end
  end

  // A load still short of W cannot supply data to the next E occupant
  always_comb begin
    w_raw_stall = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      for (int k = 0; k < S - 2; k++) begin
        if (bus.d_valid && (bus.d_rs[i*REG_AW +: REG_AW] != '0) &&
            r_vld[k] && r_ld[k] && r_wr[k] &&
            (r_rd[k] == bus.d_rs[i*REG_AW +: REG_AW])) begin
          w_raw_stall = 1'b1;
        end
      end
    end
  end

  assign bus.stall     = w_stall;
  assign bus.flush     = bus.branch_taken_e;
  assign bus.fw_sel    = w_fw_sel;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: MEM_LAT=1 and MEM_LAT=3 instances share the
// Decode stimulus; each is compared to an issue-time history model.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       d_valid;
  logic [9:0] d_rs;
  logic [4:0] d_rd;
  logic       d_we;
  logic       d_ld;
  logic       br;

  hazard_scoreboard_if #(.REG_AW(5), .N_SRC(2), .MEM_LAT(1)) bus1 ();
  hazard_scoreboard_if #(.REG_AW(5), .N_SRC(2), .MEM_LAT(3)) bus3 ();

  assign bus1.d_valid = d_valid;  assign bus3.d_valid = d_valid;
  assign bus1.d_rs    = d_rs;     assign bus3.d_rs    = d_rs;
  assign bus1.d_rd    = d_rd;     assign bus3.d_rd    = d_rd;
  assign bus1.d_we    = d_we;     assign bus3.d_we    = d_we;
  assign bus1.d_is_load = d_ld;   assign bus3.d_is_load = d_ld;
  assign bus1.branch_taken_e = br; assign bus3.branch_taken_e = br;

  hazard_scoreboard #(.REG_AW(5), .N_SRC(2), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .bus(bus1));
  hazard_scoreboard #(.REG_AW(5), .N_SRC(2), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst_n), .bus(bus3));

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // Reference: every instruction remembers the cycle it entered E; its stage
  // is simply its age in cycles.
  typedef struct {
    int       t;
    logic [4:0] rd;
    bit       wr;
    bit       ld;
    logic [4:0] rs0;
    logic [4:0] rs1;
  } rec_t;

  rec_t        h1[$];
  rec_t        h3[$];
  int          t_now = 0;
  logic [31:0] cnt1 = '0;
  logic [31:0] cnt3 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_stall(input rec_t h[$], input int ml);
    int s = ml + 2;
    int age;
    if (!d_valid || br) return 1'b0;
    foreach (h[n]) begin
      age = t_now - h[n].t;
      if (age >= 0 && age <= s - 3 && h[n].ld && h[n].wr &&
          ((d_rs[4:0] != 0 && h[n].rd == d_rs[4:0]) ||
           (d_rs[9:5] != 0 && h[n].rd == d_rs[9:5])))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_fw(input rec_t h[$], input int ml, input int op);
    int s = ml + 2;
    int best = 0;
    int age;
    bit have_e = 1'b0;
    logic [4:0] rs = '0;
    foreach (h[n]) begin
      if (t_now == h[n].t) begin
        have_e = 1'b1;
        rs = (op != 0) ? h[n].rs1 : h[n].rs0;
      end
    end
    if (!have_e || rs == 0) return 0;
    foreach (h[n]) begin
      age = t_now - h[n].t;
      if (age >= 1 && age <= s - 1 && h[n].wr && h[n].rd == rs &&
          (!h[n].ld || age == s - 1) && (best == 0 || age < best))
        best = age;
    end
    return best;
  endfunction

  function automatic bit m_hazard(input rec_t h[$], input int ml);
    int s = ml + 2;
    int age;
    rec_t e;
    bit have_e = 1'b0;
    foreach (h[n]) if (t_now == h[n].t) begin have_e = 1'b1; e = h[n]; end
    if (!have_e) return 1'b0;
    foreach (h[n]) begin
      age = t_now - h[n].t;
      if (age >= 1 && age <= s - 2 && h[n].ld && h[n].wr &&
          ((e.rs0 != 0 && h[n].rd == e.rs0) || (e.rs1 != 0 && h[n].rd == e.rs1)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] o_fw(input int j, input int op);
    if (j == 0) return 64'(bus1.fw_sel[op*2 +: 2]);
    return 64'(bus3.fw_sel[op*3 +: 3]);
  endfunction

  task automatic check_model();
    chk("m1_stall", 64'(bus1.stall), 64'(m_stall(h1, 1)));
    chk("m3_stall", 64'(bus3.stall), 64'(m_stall(h3, 3)));
    chk("m1_flush", 64'(bus1.flush), 64'(br));
    chk("m3_flush", 64'(bus3.flush), 64'(br));
    chk("m1_fw0", o_fw(0, 0), 64'(m_fw(h1, 1, 0)));
    chk("m1_fw1", o_fw(0, 1), 64'(m_fw(h1, 1, 1)));
    chk("m3_fw0", o_fw(1, 0), 64'(m_fw(h3, 3, 0)));
    chk("m3_fw1", o_fw(1, 1), 64'(m_fw(h3, 3, 1)));
    chk("m1_cnt", 64'(bus1.stall_cnt), 64'(cnt1));
    chk("m3_cnt", 64'(bus3.stall_cnt), 64'(cnt3));
    chk("m1_no_early_load", 64'(m_hazard(h1, 1)), 64'd0);
    chk("m3_no_early_load", 64'(m_hazard(h3, 3)), 64'd0);
  endtask

  task automatic update_model();
    bit   s1;
    bit   s3;
    rec_t r;
    s1 = m_stall(h1, 1);
    s3 = m_stall(h3, 3);
    t_now++;
    if (!rst_n) begin
      h1.delete(); h3.delete();
      cnt1 = '0;   cnt3 = '0;
    end else begin
      if (s1 && cnt1 != 32'hffff_ffff) cnt1 = cnt1 + 1;
      if (s3 && cnt3 != 32'hffff_ffff) cnt3 = cnt3 + 1;
      r.t = t_now; r.rd = d_rd; r.wr = d_we && (d_rd != 0); r.ld = d_ld;
      r.rs0 = d_rs[4:0]; r.rs1 = d_rs[9:5];
      if (d_valid && !br && !s1) h1.push_back(r);
      if (d_valid && !br && !s3) h3.push_back(r);
    end
    while (h1.size() > 0 && t_now - h1[0].t > 2) void'(h1.pop_front());
    while (h3.size() > 0 && t_now - h3[0].t > 4) void'(h3.pop_front());
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic step();
    check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input bit v, input int r0, input int r1, input int rd,
                     input bit we, input bit ld);
    d_valid = v;
    d_rs    = {5'(r1), 5'(r0)};
    d_rd    = 5'(rd);
    d_we    = we;
    d_ld    = ld;
  endtask

  task automatic bub();
    ins(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bub();
    settle();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    br    = 1'b0;
    bub();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state, with a redirect present
    br = 1'b1;
    settle();
    chk("rst_stall1", 64'(bus1.stall), 64'd0);
    chk("rst_stall3", 64'(bus3.stall), 64'd0);
    chk("rst_flush1", 64'(bus1.flush), 64'd1);
    chk("rst_fw1", 64'(bus1.fw_sel), 64'd0);
    chk("rst_fw3", 64'(bus3.fw_sel), 64'd0);
    chk("rst_cnt1", 64'(bus1.stall_cnt), 64'd0);
    chk("rst_cnt3", 64'(bus3.stall_cnt), 64'd0);
    step();
    br = 1'b0;

    // ALU chain
    ins(1, 1, 2, 5, 1, 0);  settle(); step();
    ins(1, 5, 0, 9, 1, 0);  settle(); step();
    ins(1, 0, 5, 10, 1, 0); settle();
    chk("alu_adj_fw1", o_fw(0, 0), 64'd1);
    chk("alu_adj_fw3", o_fw(1, 0), 64'd1);
    chk("alu_nostall1", 64'(bus1.stall), 64'd0);
    step();
    bub(); settle();
    chk("alu_gap2_fw1", o_fw(0, 1), 64'd2);
    chk("alu_gap2_fw3", o_fw(1, 1), 64'd2);
    step();

    // load-use, one memory stage
    do_reset();
    ins(1, 1, 0, 6, 1, 1);  settle(); step();
    ins(1, 3, 6, 11, 1, 0); settle();
    chk("lu1_stall", 64'(bus1.stall), 64'd1);
    step();
    settle();
    chk("lu1_release", 64'(bus1.stall), 64'd0);
    chk("lu1_bubble_fw", o_fw(0, 1), 64'd0);
    step();
    bub(); settle();
    chk("lu1_fw_w", o_fw(0, 1), 64'd2);
    chk("lu1_cnt", 64'(bus1.stall_cnt), 64'd1);
    step();

    // load-use, three memory stages
    do_reset();
    ins(1, 2, 0, 7, 1, 1);  settle(); step();
    ins(1, 7, 0, 13, 1, 0);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("lu3_stall", 64'(bus3.stall), 64'd1);
      step();
    end
    settle();
    chk("lu3_release", 64'(bus3.stall), 64'd0);
    step();
    bub(); settle();
    chk("lu3_fw_w", o_fw(1, 0), 64'd4);
    chk("lu3_cnt", 64'(bus3.stall_cnt), 64'd3);
    step();
    ins(1, 2, 0, 7, 1, 1);  settle(); step();
    for (int c = 0; c < 3; c++) begin
      ins(1, 1, 2, 12, 1, 0); settle(); step();
    end
    ins(1, 7, 0, 14, 1, 0); settle();
    chk("lu3_far_nostall", 64'(bus3.stall), 64'd0);
    step();
    bub(); settle();
    chk("lu3_far_fw", o_fw(1, 0), 64'd4);
    chk("lu3_far_cnt", 64'(bus3.stall_cnt), 64'd3);
    step();

    // youngest producer wins; x0 never tracked
    do_reset();
    ins(1, 1, 0, 8, 1, 0);  settle(); step();
    ins(1, 2, 0, 8, 1, 0);  settle(); step();
    ins(1, 8, 8, 14, 1, 0); settle(); step();
    bub(); settle();
    chk("prio_fw1_op0", o_fw(0, 0), 64'd1);
    chk("prio_fw1_op1", o_fw(0, 1), 64'd1);
    chk("prio_fw3_op0", o_fw(1, 0), 64'd1);
    step();
    ins(1, 3, 0, 0, 1, 0);  settle(); step();
    ins(1, 0, 0, 15, 1, 0); settle(); step();
    bub(); settle();
    chk("x0_fw1", 64'(bus1.fw_sel), 64'd0);
    chk("x0_fw3", 64'(bus3.fw_sel), 64'd0);
    step();
    ins(1, 4, 0, 0, 1, 1);  settle(); step();
    ins(1, 0, 0, 16, 1, 0); settle();
    chk("x0_ld_stall1", 64'(bus1.stall), 64'd0);
    chk("x0_ld_stall3", 64'(bus3.stall), 64'd0);
    step();

    // redirect during a load-use stall
    do_reset();
    ins(1, 1, 0, 6, 1, 1);  settle(); step();
    ins(1, 0, 6, 11, 1, 0); br = 1'b1; settle();
    chk("fl_stall1", 64'(bus1.stall), 64'd0);
    chk("fl_flush1", 64'(bus1.flush), 64'd1);
    chk("fl_stall3", 64'(bus3.stall), 64'd0);
    step();
    br = 1'b0;
    ins(1, 6, 0, 12, 1, 0); settle();
    chk("fl_bubble_fw1", 64'(bus1.fw_sel), 64'd0);
    chk("fl_cnt1", 64'(bus1.stall_cnt), 64'd0);
    chk("fl_noflush1", 64'(bus1.flush), 64'd0);
    step();
    bub(); settle(); step();

    // reset with loads in flight
    ins(1, 1, 0, 7, 1, 1);  settle(); step();
    ins(1, 2, 0, 9, 1, 1);  settle(); step();
    ins(1, 7, 9, 17, 1, 0); rst_n = 1'b0; settle(); step();
    rst_n = 1'b1;
    settle();
    chk("mrst_stall1", 64'(bus1.stall), 64'd0);
    chk("mrst_stall3", 64'(bus3.stall), 64'd0);
    chk("mrst_cnt1", 64'(bus1.stall_cnt), 64'd0);
    chk("mrst_cnt3", 64'(bus3.stall_cnt), 64'd0);
    chk("mrst_fw3", 64'(bus3.fw_sel), 64'd0);
    step();
    bub(); settle();
    chk("mrst_nofwd1", 64'(bus1.fw_sel), 64'd0);
    step();

    // randomized traffic on a small register window to provoke hazards
    for (int c = 0; c < 800; c++) begin
      rst_n   = ($urandom_range(99) != 0);
      d_valid = ($urandom_range(3) != 0);
      d_rs    = {5'($urandom_range(7)), 5'($urandom_range(7))};
      d_rd    = 5'($urandom_range(7));
      d_we    = ($urandom_range(4) != 0);
      d_ld    = ($urandom_range(2) == 0);
      br      = ($urandom_range(19) == 0);
      settle();
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding unit for the pipelined RISC-V core, replacing fixed E/M/W compare logic.
- Keeps its own shift-register scoreboard of in-flight destination registers from Execute through a configurable number of memory stages to Writeback.
- Drives operand-forward selects for the Execute stage, the load-use stall for Decode, and a stall-cycle performance counter.
- Sits beside the datapath; consumes Decode-stage instruction fields and the Execute-stage branch-taken signal.

Parameters:
REG_AW, 5, register address width; address 0 is hardwired zero.
N_SRC, 2, number of source operands per instruction.
MEM_LAT, 1, memory stages between E and W (>=1); load data is forwardable only from W.
S (localparam), MEM_LAT+2, scoreboard slots: slot 0 = E, slots 1..MEM_LAT = M1..Mn, slot S-1 = W.
FW_W (localparam), $clog2(S), width of each forward select.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low.
d_valid  in  1  Decode holds a real instruction.
d_rs  in  N_SRC*REG_AW  Decode source addresses, operand i at [i*REG_AW +: REG_AW].
d_rd  in  REG_AW  Decode destination address.
d_we  in  1  Decode instruction writes the register file.
d_is_load  in  1  Decode instruction is a load.
branch_taken_e  in  1  E-stage redirect; kills F and D.
stall  out  1  hold PC and F/D register; insert bubble into E.
flush  out  1  clear F/D and D/E registers (= branch_taken_e).
fw_sel  out  N_SRC*FW_W  per E operand: 0 = register file, k = forward from slot k (1..S-1).
stall_cnt  out  32  saturating count of stall cycles.

Behaviour:
- Slot entry: {valid, rd, wr, load, rs[N_SRC]}. wr = d_we & (d_rd != 0), so writes to x0 are never tracked.
- Reset (rst==0 at posedge): all slots invalid, stall_cnt=0. Consequently stall=0, flush=branch_taken_e, fw_sel=0.
- Every posedge, not in reset:
  - slot[k+1] <= slot[k] for k=0..S-2. Slot S-1 retires. Downstream slots never hold.
  - slot[0] <= bubble (valid=0) if stall | branch_taken_e | ~d_valid; otherwise Decode fields.
- Forwarding (combinational):
  - For each operand i of slot 0 with rs!=0, find the smallest k in 1..S-1 with slot[k].valid & wr & rd==rs.
  - Non-load entries qualify at any k. Load entries qualify only at k=S-1.
  - fw_sel[i]=k if found, else 0. Youngest match wins.
  - fw_sel=0 when slot 0 is invalid.
- Load-use stall:
  - raw_stall = d_valid & any i (d_rs[i]!=0 & exists k in 0..S-3 with slot[k].valid & load & wr & rd==d_rs[i]).
  - stall = raw_stall & ~branch_taken_e. Flush has priority because the D instruction is being killed.
  - One load followed immediately by a dependent instruction gives exactly MEM_LAT stall cycles.
- A load in slot k<S-1 matching an E operand cannot occur under correct stalling. The bench asserts this never happens.
- stall_cnt: +1 per cycle with stall=1. Saturates at 32'hffffffff.
- Latency: fw_sel, stall and flush are combinational from the current inputs and slots. Scoreboard update takes effect the next cycle.
- Reset mid-operation discards all in-flight entries. The first cycle after reset release has no forwarding.

Test Plan:
- ALU chain, MEM_LAT=1: add x5; next instr uses rs1=x5 -> fw_sel[0]=1 in its E cycle. Dependent two apart -> fw_sel=2. No stall.
- Load-use, MEM_LAT=1: lw x6 then add rs2=x6 -> stall=1 for 1 cycle, E bubble, then fw_sel[1]=2, stall_cnt=1.
- Load-use, MEM_LAT=3: lw x7 then dependent -> stall held 3 cycles, then fw_sel=4, stall_cnt=3. Dependent 4 instrs later -> no stall.
- Priority and x0: writes to x8 at slots 1 and 2 -> fw_sel=1. Any producer with rd=x0, or consumer with rs=x0 -> fw_sel=0, stall=0.
- Flush during stall: load-use stall with branch_taken_e=1 same cycle -> stall=0, flush=1, slot 0 bubble next cycle, stall_cnt unchanged.
- Reset mid-stream: rst=0 for one cycle with loads in flight -> next cycle all fw_sel=0, stall=0, stall_cnt=0.
